// File: rtl/mem_burst_sram.sv
// Single-port synchronous memory with byte-enable writes, fixed-length bursts
// and an RD_LAT-deep read pipeline with req_ready/rd_valid handshaking.
module mem_burst_sram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2 ** ADDR_WIDTH,
    parameter int RD_LAT     = 1,
    parameter int BURST_W    = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cs,
    input  logic                    op_en,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   addr_in,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [BURST_W-1:0]      burst_len,
    output logic                    req_ready,
    output logic                    busy,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    err
);

    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [BURST_W-1:0]      beats_left_q, beats_left_d;
    logic                    err_q, err_d;
    logic                    vld_q [RD_LAT];
    logic [DATA_WIDTH-1:0]   dat_q [RD_LAT];
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    req, addr_ok, we, issue;
    logic [ADDR_WIDTH-1:0]   acc_addr;

    // Bursts wrap at DEPTH, which need not be a power of two.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        if (32'(a) == 32'(DEPTH - 1)) return '0;
        return a + ADDR_WIDTH'(1);
    endfunction

    assign req     = cs && op_en;
    assign addr_ok = 32'(addr_in) < 32'(DEPTH);

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        err_d        = 1'b0;
        we           = 1'b0;
        issue        = 1'b0;
        acc_addr     = cur_addr_q;
        case (state_q)
            IDLE: begin
                if (req && !addr_ok) begin
                    err_d = 1'b1;
                end else if (req) begin
                    acc_addr = addr_in;
                    we       = wr_en;
                    issue    = !wr_en;
                    if (burst_len != '0) begin
                        beats_left_d = burst_len;
                        cur_addr_d   = next_addr(addr_in);
                        state_d      = wr_en ? WR_BURST : RD_BURST;
                    end
                end
            end
            WR_BURST: begin
                if (req) begin
                    we           = 1'b1;
                    cur_addr_d   = next_addr(cur_addr_q);
                    beats_left_d = beats_left_q - BURST_W'(1);
                    if (beats_left_q == BURST_W'(1)) state_d = IDLE;
                end
            end
            RD_BURST: begin
                issue        = 1'b1;
                cur_addr_d   = next_addr(cur_addr_q);
                beats_left_d = beats_left_q - BURST_W'(1);
                if (beats_left_q == BURST_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            err_q        <= 1'b0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            err_q        <= err_d;
            for (int unsigned i = RD_LAT - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            // Array is sampled at issue, so a same-edge write is not visible.
            vld_q[0] <= issue;
            dat_q[0] <= issue ? mem_q[acc_addr] : '0;
        end
    end

    // Writes are gated by reset because the array itself is never reset.
    always_ff @(posedge clk) begin
        if (we && reset_n) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (byte_en[b]) mem_q[acc_addr][8*b +: 8] <= data_in[8*b +: 8];
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign rd_valid  = vld_q[RD_LAT-1];
    assign data_out  = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_mem_burst_sram.sv
// Bench for mem_burst_sram: two instances (RD_LAT 1 and 3) share stimulus and
// are checked each cycle against a transaction-level memory model.
module tb_mem_burst_sram;

    localparam int AW  = 4;
    localparam int DW  = 16;
    localparam int DEP = 12;
    localparam int BW  = 2;
    localparam int NB  = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cs = 1'b0, op_en = 1'b0, wr_en = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic [DW-1:0] data_in = '0;
    logic [NB-1:0] byte_en = '0;
    logic [BW-1:0] burst_len = '0;

    logic          rdy1, busy1, rv1, err1;
    logic [DW-1:0] dout1;
    logic          rdy3, busy3, rv3, err3;
    logic [DW-1:0] dout3;

    mem_burst_sram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .RD_LAT(1), .BURST_W(BW)) dut1 (
        .clk(clk), .reset_n(reset_n), .cs(cs), .op_en(op_en), .wr_en(wr_en),
        .addr_in(addr_in), .data_in(data_in), .byte_en(byte_en), .burst_len(burst_len),
        .req_ready(rdy1), .busy(busy1), .data_out(dout1), .rd_valid(rv1), .err(err1));

    mem_burst_sram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .RD_LAT(3), .BURST_W(BW)) dut3 (
        .clk(clk), .reset_n(reset_n), .cs(cs), .op_en(op_en), .wr_en(wr_en),
        .addr_in(addr_in), .data_in(data_in), .byte_en(byte_en), .burst_len(burst_len),
        .req_ready(rdy3), .busy(busy3), .data_out(dout3), .rd_valid(rv3), .err(err3));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents, remaining burst beats, read history.
    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
    } rd_t;

    logic [DW-1:0] m_mem [DEP];
    int            m_wleft = 0;
    int            m_rleft = 0;
    int            m_addr  = 0;
    bit            m_err   = 1'b0;
    rd_t           hist [$];

    function automatic rd_t lat(input int l);
        if (hist.size() >= l) return hist[l-1];
        return '0;
    endfunction

    function automatic void mwrite(input int a);
        for (int b = 0; b < NB; b++)
            if (byte_en[b]) m_mem[a][8*b +: 8] = data_in[8*b +: 8];
    endfunction

    function automatic void step();
        rd_t cur;
        bit  e;
        cur = '0;
        e   = 1'b0;
        if (m_wleft > 0) begin
            if (cs && op_en) begin
                mwrite(m_addr);
                m_addr = (m_addr + 1) % DEP;
                m_wleft--;
            end
        end else if (m_rleft > 0) begin
            cur.v  = 1'b1;
            cur.d  = m_mem[m_addr];
            m_addr = (m_addr + 1) % DEP;
            m_rleft--;
        end else if (cs && op_en) begin
            if (int'(addr_in) >= DEP) begin
                e = 1'b1;
            end else begin
                if (wr_en) mwrite(int'(addr_in));
                else begin
                    cur.v = 1'b1;
                    cur.d = m_mem[addr_in];
                end
                if (burst_len != 0) begin
                    m_addr = (int'(addr_in) + 1) % DEP;
                    if (wr_en) m_wleft = int'(burst_len);
                    else       m_rleft = int'(burst_len);
                end
            end
        end
        m_err = e;
        hist.push_front(cur);
        if (hist.size() > 4) void'(hist.pop_back());
    endfunction

    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            m_wleft = 0;
            m_rleft = 0;
            m_err   = 1'b0;
            hist.delete();
        end
        check("ready1", rdy1, (m_wleft == 0 && m_rleft == 0));
        check("ready3", rdy3, (m_wleft == 0 && m_rleft == 0));
        check("busy1", busy1, (m_wleft != 0 || m_rleft != 0));
        check("busy3", busy3, (m_wleft != 0 || m_rleft != 0));
        check("err1", err1, m_err);
        check("err3", err3, m_err);
        check("rvalid1", rv1, lat(1).v);
        check("rvalid3", rv3, lat(3).v);
        if (lat(1).v) check("rdata1", dout1, lat(1).d);
        if (lat(3).v) check("rdata3", dout3, lat(3).d);
        if (reset_n) step();
    end

    task automatic drive(input bit c, input bit o, input bit w, input int a,
                         input logic [DW-1:0] d, input logic [NB-1:0] be, input int bl);
        cs = c; op_en = o; wr_en = w;
        addr_in = AW'(a); data_in = d; byte_en = be; burst_len = BW'(bl);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, '0, '0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", rdy1, 1);
        check("rst_busy", busy1, 0);
        check("rst_rvalid", rv3, 0);
        check("rst_dout", dout1, 0);
        check("rst_err", err1, 0);
        reset_n = 1'b1;

        for (int base = 0; base < DEP; base += 4) begin
            drive(1, 1, 1, base, DW'($urandom), 2'b11, 3);
            tick();
            for (int k = 1; k < 4; k++) begin
                drive(1, 1, 0, 0, DW'($urandom), 2'b11, 0);
                tick();
            end
        end
        idle(); tick();

        // Full write then read of addr 3, both latencies.
        drive(1, 1, 1, 3, 16'hA5C3, 2'b11, 0); tick();
        drive(1, 1, 0, 3, '0, '0, 0); tick();
        idle();
        check("lat1_valid", rv1, 1);
        check("lat1_data", dout1, 16'hA5C3);
        check("lat3_early", rv3, 0);
        tick();
        check("lat1_once", rv1, 0);
        tick();
        check("lat3_valid", rv3, 1);
        check("lat3_data", dout3, 16'hA5C3);

        // Low byte only.
        drive(1, 1, 1, 3, 16'hFFFF, 2'b01, 0); tick();
        drive(1, 1, 0, 3, '0, '0, 0); tick();
        idle();
        check("be_data", dout1, 16'hA5FF);
        tick();

        // Wrapping write burst at 10 then read-back.
        drive(1, 1, 1, 10, 16'd1, 2'b11, 3); tick();
        check("wb_ready_lo", rdy1, 0);
        for (int k = 2; k <= 4; k++) begin
            drive(1, 1, 0, 0, DW'(k), 2'b11, 0);
            tick();
            check("wb_ready", rdy1, (k == 4));
        end
        idle(); tick();
        drive(1, 1, 0, 10, '0, '0, 3); tick();
        idle();
        for (int k = 1; k <= 4; k++) begin
            check("rb_valid", rv1, 1);
            check("rb_data", dout1, k);
            check("rb_ready", rdy1, (k == 4));
            tick();
        end

        // Write burst with a 2-cycle op_en stall.
        drive(1, 1, 1, 5, 16'h0051, 2'b11, 3); tick();
        drive(1, 1, 0, 0, 16'h0052, 2'b11, 0); tick();
        drive(1, 0, 0, 0, 16'hDEAD, 2'b11, 0); tick(); tick();
        drive(1, 1, 0, 0, 16'h0053, 2'b11, 0); tick();
        drive(1, 1, 0, 0, 16'h0054, 2'b11, 0); tick();
        idle(); tick();
        drive(1, 1, 0, 5, '0, '0, 3); tick();
        idle();
        for (int k = 1; k <= 4; k++) begin
            check("stall_data", dout1, 16'h0050 + k);
            tick();
        end

        // Out-of-range address.
        drive(1, 1, 1, 13, 16'hBEEF, 2'b11, 0); tick();
        idle();
        check("oor_err", err1, 1);
        check("oor_ready", rdy1, 1);
        tick();
        check("oor_err_pulse", err1, 0);

        // RD_LAT=3 on addr 0 (holds 3 from the wrapping burst).
        drive(1, 1, 0, 0, '0, '0, 0); tick();
        idle();
        check("l3_c1", rv3, 0);
        tick();
        check("l3_c2", rv3, 0);
        tick();
        check("l3_c3", rv3, 1);
        check("l3_data", dout3, 3);
        tick();

        // Reset during beat 2 of a 4-beat read burst.
        drive(1, 1, 0, 0, '0, '0, 3); tick();
        idle();
        reset_n = 1'b0;
        #1;
        check("mid_rst_rv1", rv1, 0);
        check("mid_rst_dout1", dout1, 0);
        check("mid_rst_ready", rdy1, 1);
        check("mid_rst_rv3", rv3, 0);
        check("mid_rst_dout3", dout3, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        drive(1, 1, 0, 10, '0, '0, 3); tick();
        idle();
        for (int k = 1; k <= 4; k++) begin
            check("post_rst_data", dout1, k);
            tick();
        end

        for (int n = 0; n < 500; n++) begin
            drive(($urandom % 8) != 0, ($urandom % 4) != 0, $urandom % 2,
                  int'($urandom % 16), DW'($urandom), NB'($urandom), int'($urandom % 4));
            if ($urandom % 150 == 0) reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
        end
        idle();
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_burst_sram.md
Name: mem_burst_sram

Overview:
- Parametrised single-port synchronous memory with byte-enable writes, fixed-length bursts and a configurable read-latency pipeline.
- Generalises the existing 4-bit address / 8-bit data memory interface in width, depth and access mode.
- Sits behind the mem_ifc-style signal set (cs, op_en, wr_en, addr_in, data_in, data_out).
- Adds req_ready / rd_valid handshaking for driver/monitor use.

Parameters:
ADDR_WIDTH, 4, address bus width.
DATA_WIDTH, 8, data width; must be a multiple of 8.
DEPTH, 2**ADDR_WIDTH, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
RD_LAT, 1, cycles from read-beat issue to rd_valid; legal range 1..4.
BURST_W, 2, width of burst_len; max burst = 2**BURST_W beats.

Ports:
clk  input  1  clock, all logic on rising edge.
reset_n  input  1  asynchronous active-low reset.
cs  input  1  chip select.
op_en  input  1  operation enable; a beat occurs only when cs && op_en.
wr_en  input  1  1 = write request, 0 = read request (sampled at acceptance).
addr_in  input  ADDR_WIDTH  burst start address (sampled at acceptance).
data_in  input  DATA_WIDTH  write data, one word per write beat.
byte_en  input  DATA_WIDTH/8  per-byte write enable, sampled per write beat.
burst_len  input  BURST_W  beats minus one (0 = single access).
req_ready  output  1  high in IDLE; a request is accepted when cs && op_en && req_ready.
busy  output  1  high while a burst is in progress (not IDLE).
data_out  output  DATA_WIDTH  read data; valid only when rd_valid = 1.
rd_valid  output  1  one pulse per read beat, RD_LAT cycles after issue.
err  output  1  one-cycle pulse when a request with addr_in >= DEPTH is presented.

Behaviour:
- Reset (async assert, sync-released by the environment):
  - State goes to IDLE; read pipeline is flushed.
  - data_out = 0, rd_valid = 0, err = 0, busy = 0, req_ready = 1.
  - Memory array is not reset; it keeps its contents, and the initial contents are undefined.
- States: IDLE, WR_BURST, RD_BURST. Internal registers: cur_addr (ADDR_WIDTH), beats_left (BURST_W).
- IDLE:
  - With cs && op_en and addr_in >= DEPTH: err = 1 next cycle, nothing written, no read issued, and state stays IDLE.
  - With a legal address, the first beat executes in the acceptance cycle. Write: memory[addr_in] gets updated bytes per byte_en. Read: a read is issued at addr_in.
  - If burst_len == 0, stay IDLE. Otherwise load beats_left = burst_len, set cur_addr to the next address, and go to WR_BURST or RD_BURST according to wr_en.
- WR_BURST:
  - Each cycle with cs && op_en, write data_in/byte_en to cur_addr, advance cur_addr and decrement beats_left. wr_en is ignored after acceptance.
  - If op_en = 0 or cs = 0, the burst stalls: no write and counters hold.
  - After the write with beats_left == 1, go to IDLE.
- RD_BURST:
  - Issues one read per cycle unconditionally; op_en and cs are ignored.
  - After the issue with beats_left == 1, go to IDLE.
- Address advance: next = (cur_addr == DEPTH-1) ? 0 : cur_addr + 1. Bursts wrap at DEPTH, not at 2**ADDR_WIDTH.
- Read pipeline: RD_LAT-stage shift register of {valid, data}.
  - Data is sampled from the array at issue, so a write in the same cycle to the same address returns the old data (read-before-write).
  - The pipeline drains independently of state, so a new request may be accepted in IDLE while earlier reads are still in flight.
  - Back-to-back read bursts produce a gapless rd_valid stream.
- Byte enable: byte i = data_in[8i+7:8i] is written only when byte_en[i] = 1. byte_en = 0 makes the write a no-op that still consumes a beat.
- Reset mid-burst: the remaining beats are abandoned, no further writes occur, and in-flight rd_valid pulses are dropped.

Test Plan:
- DATA_WIDTH=16, RD_LAT=1: write 0xA5C3 to addr 3 with byte_en=11, then read addr 3 -> rd_valid exactly 1 cycle after issue, data_out=0xA5C3.
- Byte enables: after the above, write 0xFFFF to addr 3 with byte_en=01, then read -> data_out=0xA5FF.
- DEPTH=12, burst_len=3 write at addr 10 with data 1,2,3,4 -> addresses 10,11,0,1 hold 1,2,3,4. Read burst from 10 -> 4 consecutive rd_valid pulses with 1,2,3,4; req_ready low for 3 cycles after acceptance.
- Write-burst stall: drop op_en for 2 cycles mid-burst -> no writes during the stall, and the remaining beats land on the correct addresses when op_en returns.
- DEPTH=12, request at addr 13 -> err pulses 1 cycle, memory unchanged, req_ready stays 1. RD_LAT=3: read addr 0 -> rd_valid exactly 3 cycles after acceptance.
- Reset asserted during beat 2 of a 4-beat read burst -> rd_valid=0, data_out=0 and req_ready=1 immediately. Memory contents written before the reset read back intact afterwards.
